// File: rtl/snes_pkg.sv
// Shared definitions for the SNES controller poll path: button bit map, interface
// addresses and the poll sequencer state encoding.
package snes_pkg;

  localparam int unsigned BTN_B     = 11;
  localparam int unsigned BTN_Y     = 10;
  localparam int unsigned BTN_SEL   = 9;
  localparam int unsigned BTN_START = 8;
  localparam int unsigned BTN_UP    = 7;
  localparam int unsigned BTN_DN    = 6;
  localparam int unsigned BTN_LT    = 5;
  localparam int unsigned BTN_RT    = 4;
  localparam int unsigned BTN_A     = 3;
  localparam int unsigned BTN_X     = 2;
  localparam int unsigned BTN_L     = 1;
  localparam int unsigned BTN_R     = 0;

  localparam logic [1:0] SNES_ADDR_CTRL0 = 2'd0;
  localparam logic [1:0] SNES_ADDR_CTRL1 = 2'd1;
  localparam logic [1:0] SNES_ADDR_POLL  = 2'd2;

  typedef enum logic [2:0] {
    StIdle,
    StPoll,
    StSettle,
    StRd0,
    StCap0,
    StRd1,
    StCap1,
    StUpdate
  } poll_state_e;

endpackage

// File: rtl/snes_edge_detect.sv
// 12-bit held-state register with one-cycle press/release edges produced on update.
module snes_edge_detect (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] raw,
  input  logic        update,
  output logic [11:0] held,
  output logic [11:0] pressed,
  output logic [11:0] released
);

  logic [11:0] held_d, pressed_d, released_d;

  always_comb begin
    held_d     = held;
    pressed_d  = '0;
    released_d = '0;
    if (update) begin
      held_d     = raw;
      pressed_d  = raw & ~held;
      released_d = ~raw & held;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held     <= '0;
      pressed  <= '0;
      released <= '0;
    end else begin
      held     <= held_d;
      pressed  <= pressed_d;
      released <= released_d;
    end
  end

endmodule

// File: rtl/snes_poller.sv
// Autonomous poll sequencer for SnesInterface: periodic latch, settle, read both controllers,
// then publish held buttons with press/release edges on a single frame_valid strobe.
module snes_poller
  import snes_pkg::*;
#(
  parameter int unsigned POLL_CYCLES   = 208333,
  parameter int unsigned SETTLE_CYCLES = 64,
  parameter int unsigned CNT_W         = 18
) (
  input  logic        sys_clk,
  input  logic        sys_reset_n,
  input  logic        poll_now,
  output logic [1:0]  snes_address,
  output logic        snes_read_en,
  input  logic [11:0] snes_read_data,
  output logic [11:0] buttons_0,
  output logic [11:0] buttons_1,
  output logic [11:0] pressed_0,
  output logic [11:0] pressed_1,
  output logic [11:0] released_0,
  output logic [11:0] released_1,
  output logic        frame_valid,
  output logic        busy
);

  localparam logic [CNT_W-1:0] PollLast   = CNT_W'(POLL_CYCLES - 1);
  // Counter is 0 in the POLL cycle, so it equals cycles elapsed since poll start.
  localparam logic [CNT_W-1:0] SettleLast = CNT_W'(SETTLE_CYCLES);

  poll_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [11:0]      raw0_q;
  logic [1:0]       addr_d;
  logic             rd_en_d;
  logic             update;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    case (state_q)
      StIdle: begin
        if (poll_now || cnt_q == PollLast) begin
          state_d = StPoll;
          cnt_d   = '0;
        end
      end
      StPoll:   state_d = StSettle;
      StSettle: if (cnt_q == SettleLast) state_d = StRd0;
      StRd0:    state_d = StCap0;
      StCap0:   state_d = StRd1;
      StRd1:    state_d = StCap1;
      StCap1:   state_d = StUpdate;
      StUpdate: state_d = StIdle;
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register in line with the state.
  always_comb begin
    rd_en_d = 1'b0;
    addr_d  = SNES_ADDR_CTRL0;
    case (state_d)
      StPoll: begin
        rd_en_d = 1'b1;
        addr_d  = SNES_ADDR_POLL;
      end
      StRd0:   rd_en_d = 1'b1;
      StRd1: begin
        rd_en_d = 1'b1;
        addr_d  = SNES_ADDR_CTRL1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      raw0_q       <= '0;
      snes_read_en <= 1'b0;
      snes_address <= '0;
      busy         <= 1'b0;
      frame_valid  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      snes_read_en <= rd_en_d;
      snes_address <= addr_d;
      busy         <= (state_d != StIdle);
      frame_valid  <= update;
      if (state_q == StCap0) raw0_q <= snes_read_data;
    end
  end

  // Controller 1 data is valid during CAP1 and is taken straight into its held register,
  // so both controllers publish together in the UPDATE cycle.
  assign update = (state_q == StCap1);

  snes_edge_detect u_edge_0 (
    .clk      (sys_clk),
    .rst_n    (sys_reset_n),
    .raw      (raw0_q),
    .update   (update),
    .held     (buttons_0),
    .pressed  (pressed_0),
    .released (released_0)
  );

  snes_edge_detect u_edge_1 (
    .clk      (sys_clk),
    .rst_n    (sys_reset_n),
    .raw      (snes_read_data),
    .update   (update),
    .held     (buttons_1),
    .pressed  (pressed_1),
    .released (released_1)
  );

endmodule

// File: tb/tb_snes_poller.sv
// Scoreboard bench for snes_poller with a behavioural SnesInterface read model.
module tb_snes_poller;

  localparam int unsigned P   = 120;
  localparam int unsigned S   = 64;
  localparam int unsigned W   = 8;
  localparam int unsigned LAT = S + 5;

  logic        sys_clk = 1'b0;
  logic        sys_reset_n = 1'b0;
  logic        poll_now = 1'b0;
  logic [1:0]  snes_address;
  logic        snes_read_en;
  logic [11:0] snes_read_data = '0;
  logic [11:0] buttons_0, buttons_1, pressed_0, pressed_1, released_0, released_1;
  logic        frame_valid, busy;

  always #5 sys_clk = ~sys_clk;

  snes_poller #(
    .POLL_CYCLES   (P),
    .SETTLE_CYCLES (S),
    .CNT_W         (W)
  ) dut (
    .sys_clk        (sys_clk),
    .sys_reset_n    (sys_reset_n),
    .poll_now       (poll_now),
    .snes_address   (snes_address),
    .snes_read_en   (snes_read_en),
    .snes_read_data (snes_read_data),
    .buttons_0      (buttons_0),
    .buttons_1      (buttons_1),
    .pressed_0      (pressed_0),
    .pressed_1      (pressed_1),
    .released_0     (released_0),
    .released_1     (released_1),
    .frame_valid    (frame_valid),
    .busy           (busy)
  );

  typedef struct packed {
    logic [11:0] b0, b1, p0, p1, r0, r1;
  } frame_t;

  frame_t      exp_q[$];
  frame_t      e;
  int          tests = 0, fails = 0;
  int          cyc = 0, poll_cnt = 0, frame_cnt = 0, last_poll = -1000, latch_cyc = -1000;
  int          inv_err = 0, nreads = 0;
  logic [5:0]  seq = '0;
  logic        prev_rd = 1'b0;
  logic [11:0] next0 = '0, next1 = '0, lat0 = '0, lat1 = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic frame_t mk(input logic [11:0] b0, b1, p0, p1, r0, r1);
    frame_t f;
    f.b0 = b0; f.b1 = b1; f.p0 = p0; f.p1 = p1; f.r0 = r0; f.r1 = r1;
    return f;
  endfunction

  // SnesInterface model: latch on address 2, data registered one cycle after a read.
  // Reads issued before the shift would have finished return inverted data.
  always @(posedge sys_clk) begin
    if (snes_read_en) begin
      if (snes_address == 2'd2) begin
        lat0      <= next0;
        lat1      <= next1;
        latch_cyc <= cyc;
      end else if (snes_address == 2'd0) begin
        snes_read_data <= (cyc - latch_cyc < 56) ? ~lat0 : lat0;
      end else if (snes_address == 2'd1) begin
        snes_read_data <= (cyc - latch_cyc < 56) ? ~lat1 : lat1;
      end
    end
  end

  // Monitor: tracks read sequence and pops the scoreboard on every frame_valid.
  always @(negedge sys_clk) begin
    if (!sys_reset_n) begin
      cyc     = 0;
      seq     = '0;
      nreads  = 0;
      prev_rd = 1'b0;
    end else begin
      cyc++;
      if (snes_read_en) begin
        if (snes_address == 2'd2) begin
          poll_cnt++;
          last_poll = cyc;
          seq       = {4'b0, 2'd2};
          nreads    = 1;
        end else begin
          seq = {seq[3:0], snes_address};
          nreads++;
        end
      end
      if (snes_read_en && prev_rd) inv_err++;
      prev_rd = snes_read_en;
      if (!frame_valid && (|{pressed_0, pressed_1, released_0, released_1})) inv_err++;
      if (frame_valid) begin
        frame_cnt++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_frame: got frame %0d expected none", frame_cnt);
        end else begin
          e = exp_q.pop_front();
          check("buttons_0", buttons_0, e.b0);
          check("buttons_1", buttons_1, e.b1);
          check("pressed_0", pressed_0, e.p0);
          check("pressed_1", pressed_1, e.p1);
          check("released_0", released_0, e.r0);
          check("released_1", released_1, e.r1);
          check("latency", cyc - last_poll, LAT);
          check("read_order", {nreads[7:0], 2'b0, seq}, {8'd3, 2'b0, 2'd2, 2'd0, 2'd1});
        end
      end
    end
  end

  task automatic step();
    @(negedge sys_clk);
    #1;
  endtask

  task automatic wait_poll(input int n);
    int k = 0;
    while (poll_cnt < n && k < 3 * P) begin
      step();
      k++;
    end
    if (poll_cnt < n) begin
      tests++;
      fails++;
      $display("FAIL poll_timeout: got %0d polls expected %0d", poll_cnt, n);
    end
  endtask

  task automatic wait_frame(input int n);
    int k = 0;
    while (frame_cnt < n && k < 3 * P) begin
      step();
      k++;
    end
    if (frame_cnt < n) begin
      tests++;
      fails++;
      $display("FAIL frame_timeout: got %0d frames expected %0d", frame_cnt, n);
    end
  endtask

  task automatic wait_cyc(input int c);
    int k = 0;
    while (cyc < c && k < 3 * P) begin
      step();
      k++;
    end
  endtask

  initial begin
    int t1, t4, t5, t6, t8;
    repeat (3) step();
    check("reset_ctrl", {busy, frame_valid, snes_read_en, snes_address}, 5'd0);
    check("reset_buttons", buttons_0 | buttons_1 | pressed_0 | pressed_1 | released_0 | released_1,
          12'h0);
    next0 = 12'h800;
    next1 = 12'h001;
    exp_q.push_back(mk(12'h800, 12'h001, 12'h800, 12'h001, 12'h000, 12'h000));
    @(negedge sys_clk);
    #1 sys_reset_n = 1'b1;

    wait_poll(1);
    check("first_poll_cycle", last_poll, P);
    t1 = last_poll;
    wait_frame(1);
    next0 = 12'h808;
    exp_q.push_back(mk(12'h808, 12'h001, 12'h008, 12'h000, 12'h000, 12'h000));
    wait_poll(2);
    check("poll_period", last_poll - t1, P);
    wait_frame(2);
    next0 = 12'h008;
    next1 = 12'h000;
    exp_q.push_back(mk(12'h008, 12'h000, 12'h000, 12'h000, 12'h800, 12'h001));
    wait_poll(3);
    wait_frame(3);
    next0 = 12'h0F0;
    next1 = 12'h00F;
    exp_q.push_back(mk(12'h0F0, 12'h00F, 12'h0F0, 12'h00F, 12'h008, 12'h000));

    // poll_now pulsed during SETTLE must not add a poll
    wait_poll(4);
    t4 = last_poll;
    repeat (10) step();
    poll_now = 1'b1;
    step();
    poll_now = 1'b0;
    wait_frame(4);
    exp_q.push_back(mk(12'h0F0, 12'h00F, 12'h000, 12'h000, 12'h000, 12'h000));
    wait_poll(5);
    check("busy_poll_now_ignored", last_poll - t4, P);
    t5 = last_poll;
    wait_frame(5);

    // poll_now coinciding with the period tick gives one poll
    exp_q.push_back(mk(12'h0F0, 12'h00F, 12'h000, 12'h000, 12'h000, 12'h000));
    wait_cyc(t5 + P - 1);
    poll_now = 1'b1;
    step();
    poll_now = 1'b0;
    check("tick_poll_cycle", last_poll, t5 + P);
    check("tick_poll_count", poll_cnt, 6);
    t6 = last_poll;
    wait_frame(6);
    exp_q.push_back(mk(12'h0F0, 12'h00F, 12'h000, 12'h000, 12'h000, 12'h000));
    wait_poll(7);
    check("tick_single_poll", last_poll - t6, P);
    wait_frame(7);

    // poll_now held as a level: back-to-back polls
    exp_q.push_back(mk(12'h0F0, 12'h00F, 12'h000, 12'h000, 12'h000, 12'h000));
    exp_q.push_back(mk(12'h0F0, 12'h00F, 12'h000, 12'h000, 12'h000, 12'h000));
    poll_now = 1'b1;
    wait_poll(8);
    t8 = last_poll;
    wait_poll(9);
    poll_now = 1'b0;
    check("back_to_back_gap", last_poll - t8, LAT + 2);
    wait_frame(9);

    // Reset asserted in CAP0 aborts the poll
    wait_poll(10);
    wait_cyc(last_poll + S + 2);
    check("pre_reset_buttons_0", buttons_0, 12'h0F0);
    sys_reset_n = 1'b0;
    #1;
    check("abort_ctrl", {busy, frame_valid, snes_read_en, snes_address}, 5'd0);
    check("abort_buttons", buttons_0 | buttons_1 | pressed_0 | pressed_1 | released_0 | released_1,
          12'h0);
    repeat (3) step();
    exp_q.push_back(mk(12'h0F0, 12'h00F, 12'h0F0, 12'h00F, 12'h000, 12'h000));
    sys_reset_n = 1'b1;
    wait_poll(11);
    check("post_reset_poll_cycle", last_poll, P);
    wait_frame(10);
    repeat (5) step();

    check("scoreboard_empty", exp_q.size(), 0);
    check("frame_count", frame_cnt, 10);
    check("output_invariants", inv_err, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
